// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: off/on/blink/alternate/chase/breathe on a 1 ms time base,
// reconfigured at runtime through a single-cycle valid/ready handshake.
module led_pattern_gen #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int N_LED         = 2,
    parameter int PWM_BITS      = 8,
    parameter int RST_MODE      = 3,
    parameter int RST_PERIOD_MS = 1000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_mode,
    input  logic [15:0]      cfg_period_ms,
    output logic [N_LED-1:0] led
);
    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int POS_W    = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(N_LED - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    typedef enum logic {S_IDLE, S_APPLY} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  xfer;
    logic                  clr;
    logic [2:0]            mode_q;
    logic [15:0]           period_q;
    logic [PRE_W-1:0]      pre_cnt;
    logic                  ms_tick;
    logic                  tick_en;
    logic [15:0]           ms_cnt;
    logic [15:0]           period_eff;
    logic                  period_wrap;
    logic                  first_half;
    logic [POS_W-1:0]      chase_pos;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [PWM_BITS-1:0]   duty;
    logic                  duty_up;
    logic [N_LED-1:0]      pattern;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cfg_valid) state_nxt = S_APPLY;
            S_APPLY: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state == S_IDLE);
    end

    assign xfer = cfg_valid && cfg_ready;
    // Counters are held clear through APPLY so the new pattern starts from its beginning;
    // a transfer also swallows any tick landing on the same edge.
    assign clr  = xfer || (state == S_APPLY);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q   <= 3'(RST_MODE);
            period_q <= 16'(RST_PERIOD_MS);
        end else if (xfer) begin
            mode_q   <= cfg_mode;
            period_q <= cfg_period_ms;
        end
    end

    assign ms_tick = (pre_cnt == PRE_MAX);
    assign tick_en = ms_tick && !clr;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)   pre_cnt <= '0;
        else if (clr)     pre_cnt <= '0;
        else if (ms_tick) pre_cnt <= '0;
        else              pre_cnt <= pre_cnt + PRE_W'(1);
    end

    assign period_eff  = (period_q < 16'd2) ? 16'd2 : period_q;
    assign period_wrap = tick_en && (ms_cnt == period_eff - 16'd1);
    assign first_half  = (ms_cnt < (period_eff >> 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)       ms_cnt <= '0;
        else if (clr)         ms_cnt <= '0;
        else if (period_wrap) ms_cnt <= '0;
        else if (tick_en)     ms_cnt <= ms_cnt + 16'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)       chase_pos <= '0;
        else if (clr)         chase_pos <= '0;
        else if (period_wrap) chase_pos <= (chase_pos == POS_MAX) ? '0 : chase_pos + POS_W'(1);
    end

    // Breathe: duty ramps 0 -> max -> 0 one step per ms, compared against a free-running PWM counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt <= '0;
            duty    <= '0;
            duty_up <= 1'b1;
        end else if (clr) begin
            pwm_cnt <= '0;
            duty    <= '0;
            duty_up <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (tick_en) begin
                if (duty_up) begin
                    duty <= duty + PWM_BITS'(1);
                    if (duty == DUTY_MAX - PWM_BITS'(1)) duty_up <= 1'b0;
                end else begin
                    duty <= duty - PWM_BITS'(1);
                    if (duty == PWM_BITS'(1)) duty_up <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        pattern = '0;
        case (mode_q)
            3'd1: pattern = '1;
            3'd2: pattern = {N_LED{first_half}};
            3'd3: begin
                for (int i = 0; i < N_LED; i++) begin
                    pattern[i] = (i % 2 == 0) ? first_half : !first_half;
                end
            end
            3'd4: pattern = N_LED'(1) << chase_pos;
            3'd5: pattern = {N_LED{pwm_cnt < duty}};
            default: pattern = '0;
        endcase
    end

    // led is frozen during APPLY, so the new mode appears two cycles after the transfer edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)            led <= '0;
        else if (state == S_IDLE) led <= pattern;
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: three instances (2-LED, 4-LED chase, 1-LED fast-tick breathe).
module tb_led_pattern_gen;
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_mode = 3'd0;
    logic [15:0] a_period = 16'd0;
    logic [1:0]  a_led;

    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [2:0]  b_mode = 3'd0;
    logic [15:0] b_period = 16'd0;
    logic [3:0]  b_led;

    logic        c_valid = 1'b0;
    logic        c_ready;
    logic [2:0]  c_mode = 3'd0;
    logic [15:0] c_period = 16'd0;
    logic [0:0]  c_led;

    int n_vec = 0;
    int n_err = 0;

    led_pattern_gen #(.CLK_FREQ_HZ(4000), .N_LED(2)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_valid(a_valid), .cfg_ready(a_ready),
        .cfg_mode(a_mode), .cfg_period_ms(a_period), .led(a_led));

    led_pattern_gen #(.CLK_FREQ_HZ(4000), .N_LED(4)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_valid(b_valid), .cfg_ready(b_ready),
        .cfg_mode(b_mode), .cfg_period_ms(b_period), .led(b_led));

    led_pattern_gen #(.CLK_FREQ_HZ(1000), .N_LED(1), .PWM_BITS(3)) dut_c (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_valid(c_valid), .cfg_ready(c_ready),
        .cfg_mode(c_mode), .cfg_period_ms(c_period), .led(c_led));

    // Called at a negedge; offers one config for one edge, returns at the following negedge.
    task automatic xfer(input int sel, input logic [2:0] m, input logic [15:0] p);
        case (sel)
            0: begin a_valid = 1'b1; a_mode = m; a_period = p; end
            1: begin b_valid = 1'b1; b_mode = m; b_period = p; end
            default: begin c_valid = 1'b1; c_mode = m; c_period = p; end
        endcase
        @(negedge sys_clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        c_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge sys_clk);
        n_vec++;
        if (a_led !== 2'b00 || a_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_a: led=%b ready=%b, expected led=00 ready=1", a_led, a_ready);
        end
        n_vec++;
        if (b_led !== 4'b0000 || c_led !== 1'b0 || b_ready !== 1'b1 || c_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_bc: b_led=%b c_led=%b b_rdy=%b c_rdy=%b, expected 0000 0 1 1",
                     b_led, c_led, b_ready, c_ready);
        end
        sys_rst_n = 1'b1;
    endtask

    // Called at the negedge where reset was released; default ALTERNATE, 1000 ms on every instance.
    task automatic test_alternate_default(input int n_cyc);
        logic [1:0] ea;
        logic [3:0] eb;
        logic       ec;
        for (int k = 1; k <= n_cyc; k++) begin
            @(negedge sys_clk);
            ea = (((k - 1) / 2000) % 2 == 0) ? 2'b01 : 2'b10;
            eb = {ea, ea};
            ec = (((k - 1) / 500) % 2 == 0);
            n_vec++;
            if (a_led !== ea || b_led !== eb || c_led !== ec) begin
                n_err++;
                $display("FAIL alternate cyc %0d: a=%b b=%b c=%b, expected a=%b b=%b c=%b",
                         k, a_led, b_led, c_led, ea, eb, ec);
            end
        end
    endtask

    task automatic test_handshake_blink;
        logic [1:0] ea;
        xfer(0, 3'd2, 16'd4);
        n_vec++;
        if (a_ready !== 1'b0) begin
            n_err++;
            $display("FAIL blink_apply_ready: ready=%b, expected 0", a_ready);
        end
        @(negedge sys_clk);
        n_vec++;
        if (a_ready !== 1'b1) begin
            n_err++;
            $display("FAIL blink_idle_ready: ready=%b, expected 1", a_ready);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            ea = ((i / 8) % 2 == 0) ? 2'b11 : 2'b00;
            n_vec++;
            if (a_led !== ea) begin
                n_err++;
                $display("FAIL blink cyc %0d: led=%b, expected %b", i, a_led, ea);
            end
        end
    endtask

    task automatic test_period_min;
        logic [15:0] plist [3];
        logic [1:0]  ea;
        plist = '{16'd0, 16'd1, 16'd2};
        for (int p = 0; p < 3; p++) begin
            xfer(0, 3'd2, plist[p]);
            @(negedge sys_clk);
            for (int i = 0; i < 16; i++) begin
                @(negedge sys_clk);
                ea = ((i / 4) % 2 == 0) ? 2'b11 : 2'b00;
                n_vec++;
                if (a_led !== ea) begin
                    n_err++;
                    $display("FAIL period_%0d cyc %0d: led=%b, expected %b", plist[p], i, a_led, ea);
                end
            end
        end
    endtask

    task automatic test_mode_invalid;
        logic [2:0] mlist [2];
        mlist = '{3'd6, 3'd7};
        for (int m = 0; m < 2; m++) begin
            xfer(0, 3'd1, 16'd4);
            @(negedge sys_clk);
            @(negedge sys_clk);
            n_vec++;
            if (a_led !== 2'b11) begin
                n_err++;
                $display("FAIL mode_on_before_%0d: led=%b, expected 11", mlist[m], a_led);
            end
            xfer(0, mlist[m], 16'd4);
            @(negedge sys_clk);
            for (int i = 0; i < 12; i++) begin
                @(negedge sys_clk);
                n_vec++;
                if (a_led !== 2'b00) begin
                    n_err++;
                    $display("FAIL mode_%0d cyc %0d: led=%b, expected 00", mlist[m], i, a_led);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int   lows;
        logic er;
        lows = 0;
        a_valid = 1'b1;
        a_mode = 3'd1;
        a_period = 16'd4;
        for (int i = 1; i <= 5; i++) begin
            @(negedge sys_clk);
            er = (i % 2 == 0);
            if (a_ready === 1'b0) lows++;
            n_vec++;
            if (a_ready !== er) begin
                n_err++;
                $display("FAIL b2b_ready cyc %0d: ready=%b, expected %b", i, a_ready, er);
            end
        end
        a_valid = 1'b0;
        @(negedge sys_clk);
        n_vec++;
        if (a_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_final_ready: ready=%b, expected 1", a_ready);
        end
        n_vec++;
        if (lows !== 3) begin
            n_err++;
            $display("FAIL b2b_transfers: %0d, expected 3", lows);
        end
        @(negedge sys_clk);
        n_vec++;
        if (a_led !== 2'b11) begin
            n_err++;
            $display("FAIL b2b_led: led=%b, expected 11", a_led);
        end
    endtask

    task automatic test_chase;
        logic [3:0] eb;
        xfer(1, 3'd4, 16'd3);
        n_vec++;
        if (b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL chase_apply_ready: ready=%b, expected 0", b_ready);
        end
        @(negedge sys_clk);
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            eb = 4'b0001 << ((i / 12) % 4);
            n_vec++;
            if (b_led !== eb) begin
                n_err++;
                $display("FAIL chase cyc %0d: led=%b, expected %b", i, b_led, eb);
            end
        end
    endtask

    task automatic test_breathe;
        int   t;
        int   tri_duty;
        logic ec;
        xfer(2, 3'd5, 16'd0);
        n_vec++;
        if (c_ready !== 1'b0) begin
            n_err++;
            $display("FAIL breathe_apply_ready: ready=%b, expected 0", c_ready);
        end
        @(negedge sys_clk);
        for (int j = 0; j < 42; j++) begin
            @(negedge sys_clk);
            t = j % 14;
            tri_duty = (t <= 7) ? t : 14 - t;
            ec = ((j % 8) < tri_duty);
            n_vec++;
            if (c_led !== ec) begin
                n_err++;
                $display("FAIL breathe cyc %0d: led=%b, expected %b (duty %0d)", j, c_led, ec, tri_duty);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [1:0] ea;
        xfer(0, 3'd4, 16'd2);
        @(negedge sys_clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            ea = 2'b01 << ((i / 8) % 2);
            n_vec++;
            if (a_led !== ea) begin
                n_err++;
                $display("FAIL chase2 cyc %0d: led=%b, expected %b", i, a_led, ea);
            end
        end
        #2 sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if (a_led !== 2'b00 || a_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: led=%b ready=%b, expected led=00 ready=1", a_led, a_ready);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        test_alternate_default(2100);
    endtask

    initial begin
        test_reset;
        test_alternate_default(4400);
        test_handshake_blink;
        test_period_min;
        test_mode_invalid;
        test_back_to_back;
        test_chase;
        test_breathe;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
